// File: rtl/matrix_operand_bank_if.sv
// ============================================================================
// Module      : matrix_operand_bank_if
// Description : Multiplier and host signal bundle for matrix_operand_bank.
//               oob_err exists only when MATRIX_BANK_OOB_CHECK_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface matrix_operand_bank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic [DATA_WIDTH-1:0] x_data;
  logic [DATA_WIDTH-1:0] y_data;
  logic [ADDR_WIDTH-1:0] z_addr;
  logic [DATA_WIDTH-1:0] z_data;
  logic                  z_wen;
  logic                  mm_busy;
  logic                  mm_start;
  logic [1:0]            host_sel;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_wen;
  logic                  host_ren;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;
  logic                  host_go;
  logic                  done;
  logic                  host_err;
`ifdef MATRIX_BANK_OOB_CHECK_EN
  logic                  oob_err;
`endif

  modport slave (
    input  x_addr, y_addr, z_addr, z_data, z_wen, mm_busy,
    input  host_sel, host_addr, host_wdata, host_wen, host_ren, host_go,
    output x_data, y_data, mm_start, host_rdata, host_rvalid, done, host_err
`ifdef MATRIX_BANK_OOB_CHECK_EN
    , output oob_err
`endif
  );

  modport master (
    output x_addr, y_addr, z_addr, z_data, z_wen, mm_busy,
    output host_sel, host_addr, host_wdata, host_wen, host_ren, host_go,
    input  x_data, y_data, mm_start, host_rdata, host_rvalid, done, host_err
`ifdef MATRIX_BANK_OOB_CHECK_EN
    , input  oob_err
`endif
  );
endinterface

`default_nettype wire

// File: rtl/matrix_operand_bank.sv
// ============================================================================
// Module      : matrix_operand_bank
// Description : X/Y operand and Z result store for matrix_multiplier with a
//               host load/launch/readback port. Optional: MATRIX_BANK_OOB_CHECK_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_operand_bank #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 5,
  parameter int Y_COLS        = 5,
  parameter int X_COLS_Y_ROWS = 5
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  matrix_operand_bank_if.slave bus
);
  localparam int c_X_SIZE = X_ROWS * X_COLS_Y_ROWS;
  localparam int c_Y_SIZE = X_COLS_Y_ROWS * Y_COLS;
  localparam int c_Z_SIZE = X_ROWS * Y_COLS;
  localparam int c_XW     = (c_X_SIZE > 1) ? $clog2(c_X_SIZE) : 1;
  localparam int c_YW     = (c_Y_SIZE > 1) ? $clog2(c_Y_SIZE) : 1;
  localparam int c_ZW     = (c_Z_SIZE > 1) ? $clog2(c_Z_SIZE) : 1;
  localparam int c_ZCW    = $clog2(c_Z_SIZE + 1);
  localparam logic [ADDR_WIDTH-1:0] c_X_LIM  = ADDR_WIDTH'(c_X_SIZE);
  localparam logic [ADDR_WIDTH-1:0] c_Y_LIM  = ADDR_WIDTH'(c_Y_SIZE);
  localparam logic [ADDR_WIDTH-1:0] c_Z_LIM  = ADDR_WIDTH'(c_Z_SIZE);
  localparam logic [c_ZCW-1:0]      c_Z_LAST = c_ZCW'(c_Z_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_mm_start;

  logic [DATA_WIDTH-1:0] r_x [c_X_SIZE];
  logic [DATA_WIDTH-1:0] r_y [c_Y_SIZE];
  logic [DATA_WIDTH-1:0] r_z [c_Z_SIZE];

  logic [DATA_WIDTH-1:0] r_x_data;
  logic [DATA_WIDTH-1:0] r_y_data;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_host_rvalid;
  logic                  r_done;
  logic                  r_host_err;
  logic [c_ZCW-1:0]      r_zcount;

  logic w_x_in_rng, w_y_in_rng, w_z_in_rng;
  logic w_hx_rng, w_hy_rng, w_hz_rng;
  logic w_z_wr, w_z_cnt, w_last_write;
  logic w_host_wr_state_ok, w_host_wr_ok, w_hx_we, w_hy_we, w_host_rej;
  logic [DATA_WIDTH-1:0] w_host_rd;
  logic w_unused;

  assign w_unused   = bus.mm_busy;

  assign w_x_in_rng = bus.x_addr < c_X_LIM;
  assign w_y_in_rng = bus.y_addr < c_Y_LIM;
  assign w_z_in_rng = bus.z_addr < c_Z_LIM;
  assign w_hx_rng   = bus.host_addr < c_X_LIM;
  assign w_hy_rng   = bus.host_addr < c_Y_LIM;
  assign w_hz_rng   = bus.host_addr < c_Z_LIM;

  // Z writes land in any state; only those made during COMPUTE are counted.
  assign w_z_wr       = bus.z_wen && w_z_in_rng;
  assign w_z_cnt      = w_z_wr && (r_state == S_COMPUTE);
  assign w_last_write = w_z_cnt && (r_zcount == c_Z_LAST);

  assign w_host_wr_state_ok = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_host_wr_ok = bus.host_wen && w_host_wr_state_ok && !bus.host_sel[1];
  assign w_hx_we      = w_host_wr_ok && !bus.host_sel[0] && w_hx_rng;
  assign w_hy_we      = w_host_wr_ok &&  bus.host_sel[0] && w_hy_rng;
  assign w_host_rej   = (bus.host_go && !w_host_wr_state_ok) ||
                        (bus.host_wen && (!w_host_wr_state_ok || bus.host_sel[1]));

  always_comb begin
    w_state_next = r_state;
    w_mm_start   = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.host_go) w_state_next = S_START;
      S_START: begin
        w_mm_start   = 1'b1;
        w_state_next = S_COMPUTE;
      end
      S_COMPUTE: if (w_last_write) w_state_next = S_DONE;
      S_DONE:    if (bus.host_go) w_state_next = S_START;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_host_rd = '0;
    case (bus.host_sel)
      2'd0:    if (w_hx_rng) w_host_rd = r_x[bus.host_addr[c_XW-1:0]];
      2'd1:    if (w_hy_rng) w_host_rd = r_y[bus.host_addr[c_YW-1:0]];
      2'd2:    if (w_hz_rng) w_host_rd = r_z[bus.host_addr[c_ZW-1:0]];
      default: w_host_rd = '0;
    endcase
  end

  // Storage arrays carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_hx_we) r_x[bus.host_addr[c_XW-1:0]] <= bus.host_wdata;
    if (w_hy_we) r_y[bus.host_addr[c_YW-1:0]] <= bus.host_wdata;
    if (w_z_wr)  r_z[bus.z_addr[c_ZW-1:0]]    <= bus.z_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_x_data      <= '0;
      r_y_data      <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_done        <= 1'b0;
      r_host_err    <= 1'b0;
      r_zcount      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_done        <= w_last_write;
      r_host_rvalid <= bus.host_ren;
      r_x_data      <= w_x_in_rng ? r_x[bus.x_addr[c_XW-1:0]] : '0;
      r_y_data      <= w_y_in_rng ? r_y[bus.y_addr[c_YW-1:0]] : '0;
      if (bus.host_ren) r_host_rdata <= w_host_rd;
      // A rejection seen during START still survives the START-time clear.
      r_host_err    <= w_host_rej | (r_host_err & (r_state != S_START));
      if (r_state == S_START)
        r_zcount <= '0;
      else if (w_z_cnt)
        r_zcount <= r_zcount + 1'b1;
    end
  end

`ifdef MATRIX_BANK_OOB_CHECK_EN
  logic r_oob_err;
  logic w_oob;

  assign w_oob = !w_x_in_rng || !w_y_in_rng || (bus.z_wen && !w_z_in_rng);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_oob_err <= 1'b0;
    else        r_oob_err <= w_oob | (r_oob_err & (r_state != S_START));
  end

  assign bus.oob_err = r_oob_err;
`endif

  assign bus.x_data      = r_x_data;
  assign bus.y_data      = r_y_data;
  assign bus.mm_start    = w_mm_start;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.done        = r_done;
  assign bus.host_err    = r_host_err;
endmodule

`default_nettype wire

// File: tb/tb_matrix_operand_bank.sv
// ============================================================================
// Module      : tb_matrix_operand_bank
// Description : Directed self-checking bench for matrix_operand_bank.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matrix_operand_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  matrix_operand_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  matrix_operand_bank #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .X_ROWS(5), .Y_COLS(5), .X_COLS_Y_ROWS(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
    bus_if.host_sel = sel; bus_if.host_addr = addr; bus_if.host_wdata = data; bus_if.host_wen = 1'b1;
    step();
    bus_if.host_wen = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] sel, input logic [31:0] addr,
                           output logic [31:0] data, output logic vld);
    bus_if.host_sel = sel; bus_if.host_addr = addr; bus_if.host_ren = 1'b1;
    step();
    data = bus_if.host_rdata; vld = bus_if.host_rvalid;
    bus_if.host_ren = 1'b0;
  endtask

  task automatic pulse_go();
    bus_if.host_go = 1'b1;
    step();
    bus_if.host_go = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.x_addr = '0; bus_if.y_addr = '0; bus_if.z_addr = '0; bus_if.z_data = '0;
    bus_if.z_wen = 1'b0; bus_if.mm_busy = 1'b0; bus_if.host_sel = '0; bus_if.host_addr = '0;
    bus_if.host_wdata = '0; bus_if.host_wen = 1'b0; bus_if.host_ren = 1'b0; bus_if.host_go = 1'b0;
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({bus_if.x_data, bus_if.y_data, bus_if.host_rdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data: x=%0h y=%0h rd=%0h expected all 0", bus_if.x_data, bus_if.y_data, bus_if.host_rdata);
    end
    checks++;
    if ({bus_if.mm_start, bus_if.done, bus_if.host_rvalid, bus_if.host_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: start/done/rvalid/err=%b expected 0000",
                         {bus_if.mm_start, bus_if.done, bus_if.host_rvalid, bus_if.host_err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    logic [31:0] d;
    logic        v;
    for (int i = 0; i < 25; i++) host_write(2'd0, 32'(i), ((i / 5) == (i % 5)) ? 32'd1 : 32'd0);
    for (int i = 0; i < 25; i++) host_write(2'd1, 32'(i), 32'(i + 1));
    host_read(2'd0, 32'd6, d, v);
    checks++;
    if (d !== 32'd1 || v !== 1'b1) begin errors++; $display("FAIL load_x6: got %0d v=%b expected 1 v=1", d, v); end
    host_read(2'd1, 32'd24, d, v);
    checks++;
    if (d !== 32'd25) begin errors++; $display("FAIL load_y24: got %0d expected 25", d); end
    checks++;
    if (bus_if.host_err !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", bus_if.host_err); end
    step();
    checks++;
    if (bus_if.host_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop: got %b expected 0", bus_if.host_rvalid); end
  endtask

  task automatic test_go();
    pulse_go();
    checks++;
    if (bus_if.mm_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", bus_if.mm_start); end
    step();
    checks++;
    if (bus_if.mm_start !== 1'b0) begin errors++; $display("FAIL start_single: got %b expected 0", bus_if.mm_start); end
  endtask

  task automatic test_reads();
    bus_if.x_addr = 32'd6; bus_if.y_addr = 32'd12;
    step();
    checks++;
    if (bus_if.x_data !== 32'd1 || bus_if.y_data !== 32'd13) begin
      errors++; $display("FAIL read_inrange: x=%0d y=%0d expected x=1 y=13", bus_if.x_data, bus_if.y_data);
    end
    bus_if.x_addr = 32'd7; bus_if.y_addr = 32'd30;
    step();
    checks++;
    if (bus_if.x_data !== 32'd0 || bus_if.y_data !== 32'd0) begin
      errors++; $display("FAIL read_x7_y30: x=%0d y=%0d expected x=0 y=0", bus_if.x_data, bus_if.y_data);
    end
    bus_if.x_addr = 32'd0; bus_if.y_addr = 32'd0;
  endtask

  task automatic test_host_err();
    logic [31:0] d;
    logic        v;
    host_write(2'd0, 32'd0, 32'd99);
    checks++;
    if (bus_if.host_err !== 1'b1) begin errors++; $display("FAIL err_compute_wr: got %b expected 1", bus_if.host_err); end
    host_read(2'd0, 32'd0, d, v);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL x_unchanged: got %0d expected 1", d); end
  endtask

  task automatic test_compute();
    logic [31:0] d;
    logic        v;
    for (int i = 0; i < 25; i++) begin
      bus_if.z_wen = 1'b1; bus_if.z_addr = 32'(i); bus_if.z_data = 32'(i * 3);
      step();
      checks++;
      if (bus_if.done !== (i == 24)) begin
        errors++; $display("FAIL done_write%0d: got %b expected %b", i, bus_if.done, (i == 24));
      end
    end
    bus_if.z_wen = 1'b0;
    step();
    checks++;
    if (bus_if.done !== 1'b0) begin errors++; $display("FAIL done_single: got %b expected 0", bus_if.done); end
    checks++;
    if (bus_if.host_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_if.host_err); end
    host_read(2'd2, 32'd24, d, v);
    checks++;
    if (d !== 32'd72 || v !== 1'b1) begin errors++; $display("FAIL z24: got %0d v=%b expected 72 v=1", d, v); end
    host_read(2'd3, 32'd0, d, v);
    checks++;
    if (d !== 32'd0 || v !== 1'b1) begin errors++; $display("FAIL sel3: got %0d v=%b expected 0 v=1", d, v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        v;
    bus_if.z_wen = 1'b1; bus_if.z_addr = 32'd5; bus_if.z_data = 32'd500;
    bus_if.host_ren = 1'b1; bus_if.host_sel = 2'd2; bus_if.host_addr = 32'd5;
    step();
    bus_if.z_wen = 1'b0; bus_if.host_ren = 1'b0;
    checks++;
    if (bus_if.host_rdata !== 32'd15) begin errors++; $display("FAIL z_rd_old: got %0d expected 15", bus_if.host_rdata); end
    checks++;
    if (bus_if.done !== 1'b0) begin errors++; $display("FAIL z_done_outside: got %b expected 0", bus_if.done); end
    host_read(2'd2, 32'd5, d, v);
    checks++;
    if (d !== 32'd500) begin errors++; $display("FAIL z_rd_new: got %0d expected 500", d); end
    bus_if.x_addr = 32'd6;
    bus_if.host_sel = 2'd0; bus_if.host_addr = 32'd6; bus_if.host_wdata = 32'd77;
    bus_if.host_wen = 1'b1; bus_if.host_ren = 1'b1;
    step();
    bus_if.host_wen = 1'b0; bus_if.host_ren = 1'b0;
    checks++;
    if (bus_if.x_data !== 32'd1 || bus_if.host_rdata !== 32'd1) begin
      errors++; $display("FAIL x_hazard_old: x=%0d rd=%0d expected 1 and 1", bus_if.x_data, bus_if.host_rdata);
    end
    step();
    checks++;
    if (bus_if.x_data !== 32'd77) begin errors++; $display("FAIL x_hazard_new: got %0d expected 77", bus_if.x_data); end
    bus_if.x_addr = 32'd0;
  endtask

  task automatic test_go_clears_err();
    pulse_go();
    checks++;
    if (bus_if.mm_start !== 1'b1) begin errors++; $display("FAIL restart_pulse: got %b expected 1", bus_if.mm_start); end
    step();
    checks++;
    if (bus_if.host_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bus_if.host_err); end
    pulse_go();
    checks++;
    if (bus_if.host_err !== 1'b1 || bus_if.mm_start !== 1'b0) begin
      errors++; $display("FAIL go_in_compute: err=%b start=%b expected err=1 start=0", bus_if.host_err, bus_if.mm_start);
    end
  endtask

  task automatic test_reset_mid_compute();
    logic [31:0] d;
    logic        v;
    logic        seen;
    for (int i = 0; i < 10; i++) begin
      bus_if.z_wen = 1'b1; bus_if.z_addr = 32'(i); bus_if.z_data = 32'(i);
      step();
    end
    bus_if.z_wen = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.mm_start !== 1'b0 || bus_if.host_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: done=%b start=%b err=%b expected 0 0 0", bus_if.done, bus_if.mm_start, bus_if.host_err);
    end
    step();
    rst_n = 1'b1;
    step();
    host_write(2'd0, 32'd0, 32'd5);
    checks++;
    if (bus_if.host_err !== 1'b0) begin errors++; $display("FAIL idle_write_err: got %b expected 0", bus_if.host_err); end
    host_read(2'd0, 32'd0, d, v);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL idle_write: got %0d expected 5", d); end
    host_write(2'd2, 32'd0, 32'd1);
    checks++;
    if (bus_if.host_err !== 1'b1) begin errors++; $display("FAIL sel2_write_err: got %b expected 1", bus_if.host_err); end
    seen = 1'b0;
    for (int i = 0; i < 26; i++) begin
      bus_if.z_wen = (i < 25); bus_if.z_addr = 32'(i); bus_if.z_data = 32'(i * 3);
      step();
      seen = seen | bus_if.done;
    end
    bus_if.z_wen = 1'b0;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL no_done_idle: got %b expected 0", seen); end
    pulse_go();
    checks++;
    if (bus_if.mm_start !== 1'b1) begin errors++; $display("FAIL go_after_reset: got %b expected 1", bus_if.mm_start); end
    step();
    for (int i = 0; i < 25; i++) begin
      bus_if.z_wen = 1'b1; bus_if.z_addr = 32'(i); bus_if.z_data = 32'(i);
      step();
      if (i >= 23) begin
        checks++;
        if (bus_if.done !== (i == 24)) begin
          errors++; $display("FAIL recount%0d: got %b expected %b", i, bus_if.done, (i == 24));
        end
      end
    end
    bus_if.z_wen = 1'b0;
    step();
  endtask

`ifdef MATRIX_BANK_OOB_CHECK_EN
  task automatic test_oob();
    logic seen;
    pulse_go();
    step();
    checks++;
    if (bus_if.oob_err !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b expected 0", bus_if.oob_err); end
    bus_if.z_wen = 1'b1; bus_if.z_addr = 32'd25; bus_if.z_data = 32'd1;
    step();
    checks++;
    if (bus_if.oob_err !== 1'b1) begin errors++; $display("FAIL oob_set: got %b expected 1", bus_if.oob_err); end
    seen = bus_if.done;
    for (int i = 0; i < 24; i++) begin
      bus_if.z_addr = 32'(i);
      step();
      seen = seen | bus_if.done;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL oob_no_count: got %b expected 0", seen); end
    bus_if.z_addr = 32'd24;
    step();
    bus_if.z_wen = 1'b0;
    checks++;
    if (bus_if.done !== 1'b1) begin errors++; $display("FAIL oob_done: got %b expected 1", bus_if.done); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_go();
    test_reads();
    test_host_err();
    test_compute();
    test_back_to_back();
    test_go_clears_err();
    test_reset_mid_compute();
`ifdef MATRIX_BANK_OOB_CHECK_EN
    test_oob();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
